// File: rtl/read_addr_gen.sv
// Sliding-window read address generator: walks filter taps for each output window and
// issues paired reads to the circular IF scratchpad and the filter scratchpad.
module read_addr_gen #(
  parameter int FILT_ADDR_LEN = 4,
  parameter int IF_ADDR_LEN   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_rd_gen,
  input  logic [IF_ADDR_LEN-1:0]   if_rd_base,
  input  logic [IF_ADDR_LEN:0]     if_len,
  input  logic [FILT_ADDR_LEN:0]   filter_len,
  input  logic [IF_ADDR_LEN-1:0]   stride,
  input  logic [IF_ADDR_LEN:0]     if_valid_cnt,
  input  logic                     psum_ready,
  output logic                     rd_en,
  output logic [IF_ADDR_LEN-1:0]   if_rd_addr,
  output logic [FILT_ADDR_LEN-1:0] filt_rd_addr,
  output logic                     psum_done,
  output logic                     stride_pos_ld,
  output logic                     stride_count_flag,
  output logic                     full_done,
  output logic [1:0]               state_dbg
);

  // Wide enough that offset + stride + filter length can never overflow.
  localparam int CW = ((IF_ADDR_LEN > FILT_ADDR_LEN) ? IF_ADDR_LEN : FILT_ADDR_LEN) + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                   state;
  logic [IF_ADDR_LEN-1:0]   base_q;
  logic [IF_ADDR_LEN-1:0]   stride_q;
  logic [IF_ADDR_LEN:0]     if_len_q;
  logic [FILT_ADDR_LEN:0]   filt_len_q;
  logic [IF_ADDR_LEN:0]     w_off;
  logic [FILT_ADDR_LEN:0]   k;

  logic [CW-1:0]            tap_off;
  logic [CW-1:0]            next_end;
  logic [IF_ADDR_LEN-1:0]   rd_addr_next;
  logic [IF_ADDR_LEN-1:0]   stride_eff;
  logic                     issue;
  logic                     last_tap;
  logic                     last_win;
  logic                     degenerate;

  // Handshake: a read is issued (rd_en=1 next cycle) only on an edge where psum_ready=1 and
  // the tap's IF word has been written; otherwise rd_en=0 and every counter and address holds.
  always_comb begin
    tap_off      = CW'(w_off) + CW'(k);
    issue        = psum_ready && (tap_off < CW'(if_valid_cnt));
    last_tap     = (CW'(k) + CW'(1)) == CW'(filt_len_q);
    next_end     = CW'(w_off) + CW'(stride_q) + CW'(filt_len_q);
    last_win     = next_end > CW'(if_len_q);
    rd_addr_next = base_q + w_off[IF_ADDR_LEN-1:0] + IF_ADDR_LEN'(k);
    stride_eff   = (stride == '0) ? IF_ADDR_LEN'(1) : stride;
    degenerate   = (filter_len == '0) || (CW'(filter_len) > CW'(if_len));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      base_q            <= '0;
      stride_q          <= '0;
      if_len_q          <= '0;
      filt_len_q        <= '0;
      w_off             <= '0;
      k                 <= '0;
      rd_en             <= 1'b0;
      if_rd_addr        <= '0;
      filt_rd_addr      <= '0;
      psum_done         <= 1'b0;
      stride_pos_ld     <= 1'b0;
      stride_count_flag <= 1'b0;
      full_done         <= 1'b0;
    end else begin
      rd_en             <= 1'b0;
      psum_done         <= 1'b0;
      stride_pos_ld     <= 1'b0;
      stride_count_flag <= 1'b0;
      full_done         <= 1'b0;
      // A start in any state restarts cleanly; an aborted run never reports full_done.
      if (start_rd_gen) begin
        base_q     <= if_rd_base;
        if_len_q   <= if_len;
        filt_len_q <= filter_len;
        stride_q   <= stride_eff;
        w_off      <= '0;
        k          <= '0;
        state      <= degenerate ? FIN : RUN;
      end else begin
        case (state)
          RUN: begin
            if (issue) begin
              rd_en        <= 1'b1;
              if_rd_addr   <= rd_addr_next;
              filt_rd_addr <= k[FILT_ADDR_LEN-1:0];
              if (last_tap) begin
                psum_done <= 1'b1;
                k         <= '0;
                if (last_win) begin
                  stride_count_flag <= 1'b1;
                  state             <= FIN;
                end else begin
                  stride_pos_ld <= 1'b1;
                  w_off         <= w_off + (IF_ADDR_LEN+1)'(stride_q);
                end
              end else begin
                k <= k + 1'b1;
              end
            end
          end
          FIN: begin
            full_done <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_read_addr_gen.sv
// Directed bench for read_addr_gen: each task runs one scenario and checks the captured
// read stream, pulses and full_done timing against hand-computed expectations.
module tb_read_addr_gen;

  localparam int FA = 4;
  localparam int IA = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_rd_gen = 1'b0;
  logic [IA-1:0] if_rd_base = '0;
  logic [IA:0]   if_len = '0;
  logic [FA:0]   filter_len = '0;
  logic [IA-1:0] stride = '0;
  logic [IA:0]   if_valid_cnt = '0;
  logic          psum_ready = 1'b0;
  logic          rd_en;
  logic [IA-1:0] if_rd_addr;
  logic [FA-1:0] filt_rd_addr;
  logic          psum_done;
  logic          stride_pos_ld;
  logic          stride_count_flag;
  logic          full_done;
  logic [1:0]    state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  // captured read stream and per-run statistics
  logic [IA-1:0] obs_if[$];
  logic [FA-1:0] obs_filt[$];
  logic [2:0]    obs_fl[$];
  logic [IA-1:0] exp_q[$];
  int first_s, last_s, fd_cnt, fd_s, viol, hold_err, zero_err;
  logic restart_rd;

  // hand-computed IF addresses for if_len=8, filter_len=3, stride=1, base 0
  logic [IA-1:0] basic_if [18] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd2, 4'd3, 4'd4,
                                   4'd3, 4'd4, 4'd5, 4'd4, 4'd5, 4'd6, 4'd5, 4'd6, 4'd7};

  always #5 clk = ~clk;

  read_addr_gen #(.FILT_ADDR_LEN(FA), .IF_ADDR_LEN(IA)) dut (
    .clk(clk), .rst(rst), .start_rd_gen(start_rd_gen), .if_rd_base(if_rd_base),
    .if_len(if_len), .filter_len(filter_len), .stride(stride), .if_valid_cnt(if_valid_cnt),
    .psum_ready(psum_ready), .rd_en(rd_en), .if_rd_addr(if_rd_addr),
    .filt_rd_addr(filt_rd_addr), .psum_done(psum_done), .stride_pos_ld(stride_pos_ld),
    .stride_count_flag(stride_count_flag), .full_done(full_done), .state_dbg(state_dbg)
  );

  // Driver: start a run, then sample once per cycle at negedge. Sample s reflects the
  // posedge s cycles after the start edge. abort_kind 1 = reset, 2 = restart, at read abort_read.
  task automatic collect(input logic [IA-1:0] base, input logic [IA:0] ilen,
                         input logic [FA:0] flen, input logic [IA-1:0] str, input bit bp,
                         input int abort_kind, input int abort_read, input int max_cycles);
    int stop_s, abort_s;
    bit aborted;
    logic prev_ready;
    logic [IA:0] prev_valid;
    logic [IA-1:0] off;
    obs_if.delete(); obs_filt.delete(); obs_fl.delete();
    first_s = 0; last_s = 0; fd_cnt = 0; fd_s = 0; viol = 0; hold_err = 0; zero_err = 0;
    restart_rd = 1'b0; stop_s = 0; abort_s = 0; aborted = 1'b0;
    @(negedge clk);
    if_rd_base = base; if_len = ilen; filter_len = flen; stride = str; start_rd_gen = 1'b1;
    psum_ready = !bp;
    if_valid_cnt = bp ? '0 : ilen;
    @(negedge clk);
    start_rd_gen = 1'b0;
    prev_ready = psum_ready;
    prev_valid = if_valid_cnt;
    for (int s = 1; s <= max_cycles; s++) begin
      @(negedge clk);
      if (aborted && s == abort_s + 1) begin
        if (abort_kind == 1 && (rd_en || psum_done || stride_pos_ld || stride_count_flag ||
            full_done || if_rd_addr != '0 || filt_rd_addr != '0)) zero_err++;
        restart_rd = rd_en;
        rst = 1'b1;
        start_rd_gen = 1'b0;
      end
      if (rd_en) begin
        if (first_s == 0) first_s = s;
        last_s = s;
        obs_if.push_back(if_rd_addr);
        obs_filt.push_back(filt_rd_addr);
        obs_fl.push_back({psum_done, stride_pos_ld, stride_count_flag});
        off = if_rd_addr - base;
        if (!prev_ready || {1'b0, off} >= prev_valid) viol++;
      end else begin
        if (psum_done || stride_pos_ld || stride_count_flag) viol++;
        if (!aborted && obs_if.size() > 0 &&
            (if_rd_addr !== obs_if[$] || filt_rd_addr !== obs_filt[$])) hold_err++;
      end
      if (stride_pos_ld && stride_count_flag) viol++;
      if (full_done) begin
        fd_cnt++;
        fd_s = s;
        if (stop_s == 0) stop_s = s + 3;
      end
      if (abort_kind != 0 && !aborted && rd_en && obs_if.size() == abort_read) begin
        aborted = 1'b1;
        abort_s = s;
        if (abort_kind == 1) rst = 1'b0;
        else start_rd_gen = 1'b1;
      end
      if (bp) begin
        if (s % 2 == 0 && if_valid_cnt < ilen) if_valid_cnt++;
        psum_ready = 1'($urandom_range(0, 1));
      end
      prev_ready = psum_ready;
      prev_valid = if_valid_cnt;
      if (stop_s != 0 && s >= stop_s) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rd_en, psum_done, stride_pos_ld, stride_count_flag, full_done} !== 5'b0 ||
        if_rd_addr !== '0 || filt_rd_addr !== '0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rd_en=%b addr=%0d filt=%0d state=%0d, required all 0",
               rd_en, if_rd_addr, filt_rd_addr, state_dbg);
    end
    start_rd_gen = 1'b1; if_len = 5'd8; filter_len = 5'd3;
    @(negedge clk);
    start_rd_gen = 1'b0;
    @(negedge clk);
    tests_run++;
    if (state_dbg !== 2'd0 || full_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_over_start: state=%0d full_done=%b, required 0 0", state_dbg, full_done);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [2:0] exp_fl;
    collect(4'd0, 5'd8, 5'd3, 4'd1, 1'b0, 0, 0, 60);
    tests_run++;
    if (obs_if.size() != 18 || first_s != 1 || fd_cnt != 1 || fd_s != 19) begin
      tests_failed++;
      $display("FAIL basic_timing: reads=%0d first=%0d fd_cnt=%0d fd_at=%0d, required 18 1 1 19",
               obs_if.size(), first_s, fd_cnt, fd_s);
    end
    for (int i = 0; i < 18 && i < obs_if.size(); i++) begin
      exp_fl = {i % 3 == 2, (i % 3 == 2) && (i != 17), i == 17};
      tests_run++;
      if (obs_if[i] !== basic_if[i] || obs_filt[i] !== FA'(i % 3) || obs_fl[i] !== exp_fl) begin
        tests_failed++;
        $display("FAIL basic_read[%0d]: if=%0d filt=%0d flags=%b, required %0d %0d %b",
                 i, obs_if[i], obs_filt[i], obs_fl[i], basic_if[i], i % 3, exp_fl);
      end
    end
    tests_run++;
    if (viol != 0 || hold_err != 0) begin
      tests_failed++;
      $display("FAIL basic_protocol: viol=%0d hold_err=%0d, required 0 0", viol, hold_err);
    end
  endtask

  task automatic test_stride2();
    logic [2:0] exp_fl;
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8};
    collect(4'd0, 5'd9, 5'd3, 4'd2, 1'b0, 0, 0, 60);
    tests_run++;
    if (obs_if.size() != 12 || fd_cnt != 1 || fd_s != last_s + 1) begin
      tests_failed++;
      $display("FAIL stride2_count: reads=%0d fd_cnt=%0d fd_at=%0d last=%0d, required 12 1 last+1",
               obs_if.size(), fd_cnt, fd_s, last_s);
    end
    for (int i = 0; i < 12 && i < obs_if.size(); i++) begin
      exp_fl = {i % 3 == 2, (i % 3 == 2) && (i != 11), i == 11};
      tests_run++;
      if (obs_if[i] !== exp_q[i] || obs_filt[i] !== FA'(i % 3) || obs_fl[i] !== exp_fl) begin
        tests_failed++;
        $display("FAIL stride2_read[%0d]: if=%0d filt=%0d flags=%b, required %0d %0d %b",
                 i, obs_if[i], obs_filt[i], obs_fl[i], exp_q[i], i % 3, exp_fl);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_fl;
    exp_q = '{4'd14, 4'd15, 4'd0, 4'd15, 4'd0, 4'd1, 4'd0, 4'd1, 4'd2};
    collect(4'd14, 5'd5, 5'd3, 4'd1, 1'b0, 0, 0, 40);
    tests_run++;
    if (obs_if.size() != 9 || fd_cnt != 1 || fd_s != 10) begin
      tests_failed++;
      $display("FAIL wrap_count: reads=%0d fd_cnt=%0d fd_at=%0d, required 9 1 10",
               obs_if.size(), fd_cnt, fd_s);
    end
    for (int i = 0; i < 9 && i < obs_if.size(); i++) begin
      exp_fl = {i % 3 == 2, (i % 3 == 2) && (i != 8), i == 8};
      tests_run++;
      if (obs_if[i] !== exp_q[i] || obs_filt[i] !== FA'(i % 3) || obs_fl[i] !== exp_fl) begin
        tests_failed++;
        $display("FAIL wrap_read[%0d]: if=%0d filt=%0d flags=%b, required %0d %0d %b",
                 i, obs_if[i], obs_filt[i], obs_fl[i], exp_q[i], i % 3, exp_fl);
      end
    end
  endtask

  task automatic test_stride_zero();
    collect(4'd0, 5'd8, 5'd3, 4'd0, 1'b0, 0, 0, 60);
    tests_run++;
    if (obs_if.size() != 18 || fd_cnt != 1) begin
      tests_failed++;
      $display("FAIL stride0_count: reads=%0d fd_cnt=%0d, required 18 1", obs_if.size(), fd_cnt);
    end
    for (int i = 0; i < 18 && i < obs_if.size(); i++) begin
      tests_run++;
      if (obs_if[i] !== basic_if[i]) begin
        tests_failed++;
        $display("FAIL stride0_read[%0d]: if=%0d, required %0d", i, obs_if[i], basic_if[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_fl;
    collect(4'd0, 5'd8, 5'd3, 4'd1, 1'b1, 0, 0, 300);
    tests_run++;
    if (obs_if.size() != 18 || fd_cnt != 1 || fd_s != last_s + 1) begin
      tests_failed++;
      $display("FAIL bp_count: reads=%0d fd_cnt=%0d fd_at=%0d last=%0d, required 18 1 last+1",
               obs_if.size(), fd_cnt, fd_s, last_s);
    end
    for (int i = 0; i < 18 && i < obs_if.size(); i++) begin
      exp_fl = {i % 3 == 2, (i % 3 == 2) && (i != 17), i == 17};
      tests_run++;
      if (obs_if[i] !== basic_if[i] || obs_filt[i] !== FA'(i % 3) || obs_fl[i] !== exp_fl) begin
        tests_failed++;
        $display("FAIL bp_read[%0d]: if=%0d filt=%0d flags=%b, required %0d %0d %b",
                 i, obs_if[i], obs_filt[i], obs_fl[i], basic_if[i], i % 3, exp_fl);
      end
    end
    tests_run++;
    if (viol != 0 || hold_err != 0) begin
      tests_failed++;
      $display("FAIL bp_protocol: viol=%0d hold_err=%0d, required 0 0", viol, hold_err);
    end
  endtask

  task automatic test_degenerate();
    collect(4'd0, 5'd8, 5'd9, 4'd1, 1'b0, 0, 0, 20);
    tests_run++;
    if (obs_if.size() != 0 || fd_cnt != 1 || fd_s != 1) begin
      tests_failed++;
      $display("FAIL degen_long: reads=%0d fd_cnt=%0d fd_at=%0d, required 0 1 1",
               obs_if.size(), fd_cnt, fd_s);
    end
    collect(4'd0, 5'd8, 5'd0, 4'd1, 1'b0, 0, 0, 20);
    tests_run++;
    if (obs_if.size() != 0 || fd_cnt != 1 || fd_s != 1) begin
      tests_failed++;
      $display("FAIL degen_zero: reads=%0d fd_cnt=%0d fd_at=%0d, required 0 1 1",
               obs_if.size(), fd_cnt, fd_s);
    end
  endtask

  task automatic test_mid_reset();
    collect(4'd0, 5'd8, 5'd3, 4'd1, 1'b0, 1, 7, 30);
    tests_run++;
    if (obs_if.size() != 7 || zero_err != 0 || fd_cnt != 0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: reads=%0d zero_err=%0d fd_cnt=%0d state=%0d, required 7 0 0 0",
               obs_if.size(), zero_err, fd_cnt, state_dbg);
    end
  endtask

  task automatic test_restart();
    int j;
    collect(4'd0, 5'd8, 5'd3, 4'd1, 1'b0, 2, 7, 80);
    tests_run++;
    if (obs_if.size() != 25 || restart_rd !== 1'b0 || fd_cnt != 1) begin
      tests_failed++;
      $display("FAIL restart_count: reads=%0d rd_on_restart=%b fd_cnt=%0d, required 25 0 1",
               obs_if.size(), restart_rd, fd_cnt);
    end
    for (int i = 0; i < 25 && i < obs_if.size(); i++) begin
      j = (i < 7) ? i : i - 7;
      tests_run++;
      if (obs_if[i] !== basic_if[j] || obs_filt[i] !== FA'(j % 3)) begin
        tests_failed++;
        $display("FAIL restart_read[%0d]: if=%0d filt=%0d, required %0d %0d",
                 i, obs_if[i], obs_filt[i], basic_if[j], j % 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride2();
    test_wrap();
    test_stride_zero();
    test_backpressure();
    test_degenerate();
    test_mid_reset();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
